// File: rtl/dot_product_pkg.sv
// Shared register map, FSM encoding and batch size for the dot-product sequencer and accelerator.
package dot_product_pkg;

    localparam int unsigned DefaultBatch = 16;

    localparam logic [7:0] HostControl  = 8'h00;
    localparam logic [7:0] HostLength   = 8'h04;
    localparam logic [7:0] HostSrcA     = 8'h08;
    localparam logic [7:0] HostSrcB     = 8'h0C;
    localparam logic [7:0] HostResultLo = 8'h10;
    localparam logic [7:0] HostResultHi = 8'h14;
    localparam logic [7:0] HostBatches  = 8'h18;

    localparam logic [7:0] AccControl  = 8'h00;
    localparam logic [7:0] AccLength   = 8'h04;
    localparam logic [7:0] AccResultLo = 8'h08;
    localparam logic [7:0] AccResultHi = 8'h0C;
    localparam logic [7:0] AccBufA     = 8'h10;
    localparam logic [7:0] AccBufB     = 8'h50;

    typedef enum logic [3:0] {
        StIdle,
        StSetLen,
        StLoadA,
        StLoadB,
        StKick,
        StPoll,
        StRdLo,
        StRdHi,
        StAccum,
        StFinish
    } state_e;

    function automatic logic [7:0] buf_addr(input logic [7:0] base, input logic [7:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/dps_acc_port.sv
// One-shot accelerator access generator: each access strobes acc_valid for a single cycle and is
// always followed by an idle cycle. An access not accepted by acc_ready is retried after the gap.
module dps_acc_port (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        abort,
    input  logic        req,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        acc_valid,
    output logic        acc_write,
    output logic [7:0]  acc_addr,
    output logic [31:0] acc_wdata,
    input  logic [31:0] acc_rdata,
    input  logic        acc_ready
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_valid <= 1'b0;
            acc_write <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (abort || acc_valid) begin
            // Dropping valid here is what creates the mandatory idle cycle.
            acc_valid <= 1'b0;
            acc_write <= 1'b0;
        end else if (req) begin
            acc_valid <= 1'b1;
            acc_write <= req_write;
            acc_addr  <= req_addr;
            acc_wdata <= req_wdata;
        end
    end

    assign done  = acc_valid && acc_ready;
    assign rdata = acc_rdata;

endmodule

// File: rtl/dot_product_sequencer.sv
// Host-programmed sequencer that streams vectors A and B from memory into the dot-product
// accelerator in batches and accumulates the signed 64-bit batch results.
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int unsigned BATCH = DefaultBatch,
    parameter int unsigned LEN_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic        write,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        acc_valid,
    output logic        acc_write,
    output logic [7:0]  acc_addr,
    output logic [31:0] acc_wdata,
    input  logic [31:0] acc_rdata,
    input  logic        acc_ready,
    output logic        irq
);

    state_e           state_q;
    logic             busy_q, done_q, irq_q;
    logic [LEN_W-1:0] length_q, remaining_q, idx_q;
    logic [31:0]      src_a_q, src_b_q, batches_q, lo_q, data_q, mem_addr_q;
    logic [63:0]      result_q, batch_q;
    logic             mem_valid_q, data_vld_q;

    logic             host_wr, start, abort, last_elem;
    logic [LEN_W-1:0] n_cur;
    logic [31:0]      n_bytes, fetch_addr;
    logic             acc_req, acc_req_write, acc_done;
    logic [7:0]       acc_req_addr;
    logic [31:0]      acc_req_wdata, acc_rd;

    assign host_wr    = valid && write;
    assign start      = host_wr && (addr == HostControl) && wdata[0];
    assign abort      = host_wr && (addr == HostControl) && wdata[1];
    assign n_cur      = (remaining_q > LEN_W'(BATCH)) ? LEN_W'(BATCH) : remaining_q;
    assign n_bytes    = 32'(n_cur) << 2;
    assign last_elem  = (idx_q == n_cur - LEN_W'(1));
    assign fetch_addr = ((state_q == StLoadA) ? src_a_q : src_b_q) + (32'(idx_q) << 2);

    always_comb begin
        acc_req       = 1'b0;
        acc_req_write = 1'b1;
        acc_req_addr  = '0;
        acc_req_wdata = '0;
        case (state_q)
            StSetLen: begin
                acc_req       = 1'b1;
                acc_req_addr  = AccLength;
                acc_req_wdata = 32'(n_cur);
            end
            StLoadA, StLoadB: begin
                acc_req       = data_vld_q;
                acc_req_addr  = buf_addr((state_q == StLoadA) ? AccBufA : AccBufB, 8'(idx_q));
                acc_req_wdata = data_q;
            end
            StKick: begin
                acc_req       = 1'b1;
                acc_req_addr  = AccControl;
                acc_req_wdata = 32'd1;
            end
            StPoll, StRdLo, StRdHi: begin
                acc_req       = 1'b1;
                acc_req_write = 1'b0;
                acc_req_addr  = (state_q == StPoll) ? AccControl :
                                (state_q == StRdLo) ? AccResultLo : AccResultHi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            length_q    <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            batches_q   <= '0;
            lo_q        <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            result_q    <= '0;
            batch_q     <= '0;
            mem_valid_q <= 1'b0;
            data_vld_q  <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (host_wr && !busy_q) begin
                case (addr)
                    HostLength: length_q <= wdata[LEN_W-1:0];
                    HostSrcA:   src_a_q  <= wdata;
                    HostSrcB:   src_b_q  <= wdata;
                    default: ;
                endcase
            end
            // Abort wins over any handshake completing in the same cycle.
            if (abort) begin
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                mem_valid_q <= 1'b0;
                data_vld_q  <= 1'b0;
                idx_q       <= '0;
            end else begin
                case (state_q)
                    StIdle: if (start) begin
                        result_q    <= '0;
                        batches_q   <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        remaining_q <= length_q;
                        idx_q       <= '0;
                        state_q     <= (length_q == '0) ? StFinish : StSetLen;
                    end
                    StSetLen: if (acc_done) state_q <= StLoadA;
                    StLoadA, StLoadB: begin
                        if (!data_vld_q && !mem_valid_q) begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= fetch_addr;
                        end
                        if (mem_valid_q && mem_ready) begin
                            mem_valid_q <= 1'b0;
                            data_q      <= mem_rdata;
                            data_vld_q  <= 1'b1;
                        end
                        if (acc_done) begin
                            data_vld_q <= 1'b0;
                            if (last_elem) begin
                                idx_q   <= '0;
                                state_q <= (state_q == StLoadA) ? StLoadB : StKick;
                            end else begin
                                idx_q <= idx_q + LEN_W'(1);
                            end
                        end
                    end
                    StKick: if (acc_done) state_q <= StPoll;
                    StPoll: if (acc_done && !acc_rd[0]) state_q <= StRdLo;
                    StRdLo: if (acc_done) begin
                        lo_q    <= acc_rd;
                        state_q <= StRdHi;
                    end
                    StRdHi: if (acc_done) begin
                        batch_q <= {acc_rd, lo_q};
                        state_q <= StAccum;
                    end
                    StAccum: begin
                        result_q    <= result_q + batch_q;
                        remaining_q <= remaining_q - n_cur;
                        src_a_q     <= src_a_q + n_bytes;
                        src_b_q     <= src_b_q + n_bytes;
                        batches_q   <= batches_q + 32'd1;
                        state_q     <= (remaining_q != n_cur) ? StSetLen : StFinish;
                    end
                    StFinish: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    dps_acc_port u_acc_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .req       (acc_req),
        .req_write (acc_req_write),
        .req_addr  (acc_req_addr),
        .req_wdata (acc_req_wdata),
        .done      (acc_done),
        .rdata     (acc_rd),
        .acc_valid (acc_valid),
        .acc_write (acc_write),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .acc_rdata (acc_rdata),
        .acc_ready (acc_ready)
    );

    always_comb begin
        rdata = '0;
        case (addr)
            HostControl:  rdata = {30'd0, done_q, busy_q};
            HostLength:   rdata = 32'(length_q);
            HostSrcA:     rdata = src_a_q;
            HostSrcB:     rdata = src_b_q;
            HostResultLo: rdata = result_q[31:0];
            HostResultHi: rdata = result_q[63:32];
            HostBatches:  rdata = batches_q;
            default: ;
        endcase
    end

    assign ready     = valid;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign irq       = irq_q;

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter BATCH, default 16: maximum elements per accelerator batch.
REQ-002 SHALL have parameter LEN_W, default 16: width of the total-length register.
REQ-003 SHALL have port clk, input, 1: single clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have host slave ports valid, write (in, 1), addr (in, 8), wdata (in, 32), rdata (out, 32), ready (out, 1): CPU register port.
REQ-006 SHALL have memory read master ports mem_valid (out, 1), mem_addr (out, 32, byte address), mem_rdata (in, 32), mem_ready (in, 1).
REQ-007 SHALL have accelerator master ports acc_valid, acc_write (out, 1), acc_addr (out, 8), acc_wdata (out, 32), acc_rdata (in, 32), acc_ready (in, 1).
REQ-008 SHALL have port irq, output, 1: one-cycle pulse when a job completes.

Function
REQ-009 Host map: 0x00 CONTROL (write bit0=start, bit1=abort; read bit0=busy, bit1=done); 0x04 LENGTH; 0x08 SRC_A; 0x0C SRC_B; 0x10 RESULT_LO; 0x14 RESULT_HI; 0x18 BATCHES (read-only). Other offsets read 0, writes ignored.
REQ-010 ready SHALL equal valid; rdata combinational from addr.
REQ-011 Writes to 0x04-0x0C while busy SHALL be ignored.
REQ-012 Start while busy SHALL be ignored; start while idle clears result, BATCHES and done, and sets busy.
REQ-013 FSM states: IDLE, SET_LEN, LOAD_A, LOAD_B, KICK, POLL, RD_LO, RD_HI, ACCUM, FINISH.
REQ-014 Each batch uses n = min(BATCH, remaining) elements.
REQ-015 Batch sequence: SET_LEN writes n to acc 0x04. LOAD_A fetches n words from SRC_A+4i and writes them to acc 0x10+4i. LOAD_B does the same from SRC_B+4i to acc 0x50+4i. KICK writes 1 to acc 0x00. POLL reads acc 0x00 until bit0=0. RD_LO reads acc 0x08; RD_HI reads acc 0x0C. ACCUM adds the signed 64-bit batch result to RESULT.
REQ-016 After ACCUM: remaining -= n, SRC_A/SRC_B advance by 4n, BATCHES += 1. Return to SET_LEN if remaining > 0, else go to FINISH.
REQ-017 FINISH SHALL clear busy, set done and pulse irq for one cycle, then go to IDLE.
REQ-018 Start with LENGTH=0 SHALL go directly to FINISH with RESULT=0 and BATCHES=0.
REQ-019 mem_valid SHALL stay high with a stable mem_addr until mem_ready; at most one memory request is outstanding.
REQ-020 acc_valid SHALL be high for exactly one cycle per access, followed by at least one low cycle before the next access.
REQ-021 RESULT SHALL be a 64-bit two's-complement accumulator that wraps on overflow without saturation.
REQ-022 Abort SHALL drop mem_valid and acc_valid and return to IDLE on the next cycle with busy=0 and done=0. RESULT holds the partial value; no irq is issued.
REQ-023 A memory handshake completing in the same cycle as an abort SHALL be discarded.

Reset
REQ-024 On reset_n=0 at a clk edge, all state SHALL clear: FSM=IDLE, busy=0, done=0, irq=0, mem_valid=0, acc_valid=0, acc_write=0, and all registers and RESULT = 0.
REQ-025 Reset mid-job SHALL behave identically to REQ-024 with no further bus activity.

Structure
REQ-026 Host and accelerator register offsets, state encodings and BATCH SHALL live in shared package dot_product_pkg, also used by the accelerator.
REQ-027 The one-shot access generator with its idle gap (REQ-020) SHALL be sub-module dps_acc_port.

Verification
REQ-028 LENGTH=0, start -> FINISH within 2 cycles, RESULT=0, irq pulses once, no mem or acc traffic.
REQ-029 LENGTH=5, A=[1,2,3,4,5], B=[2,2,2,2,2] -> acc LENGTH write=5, RESULT_LO=30, RESULT_HI=0, BATCHES=1.
REQ-030 LENGTH=37, all A=B=3 -> batches of 16/16/5, RESULT_LO=333, BATCHES=3, SRC addresses advance by 64 then 64.
REQ-031 LENGTH=2, A=[0x7FFFFFFF, 0x7FFFFFFF], B=[0x7FFFFFFF, 0x7FFFFFFF] -> RESULT=0x7FFFFFFE_00000002; negative case A=[-1], B=[1] -> RESULT_HI=0xFFFFFFFF.
REQ-032 Start mid-job and LENGTH write mid-job are ignored; abort during POLL -> idle next cycle with no irq; reset during LOAD_B -> all outputs at reset values.
REQ-033 mem_ready delayed 0-5 random cycles -> mem_addr stable while waiting and RESULT unchanged versus zero-wait run.
